// File: rtl/sdram_arbit_pkg.sv
// Shared constants and types for the SDRAM command arbiter.
// The arbiter states and the idle command word live here.
package sdram_arbit_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam int         DATA_W  = 16;

  typedef enum logic [2:0] {
    ARB_INIT  = 3'b000,
    ARB_IDLE  = 3'b001,
    ARB_AREF  = 3'b010,
    ARB_WRITE = 3'b011,
    ARB_READ  = 3'b100
  } arb_state_e;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  bank;
    logic [12:0] addr;
  } sdram_cmd_t;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM pin arbiter: holds the bus for init, then grants refresh > write > read
// one owner at a time, non-preemptive, and muxes the owner onto the pins.
module sdram_arbit
  import sdram_arbit_pkg::*;
(
  input  logic              arbit_clk,
  input  logic              arbit_rst_n,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_bank,
  input  logic [12:0]       init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_bank,
  input  logic [12:0]       aref_addr,
  input  logic              aref_end,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_bank,
  input  logic [12:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_dq,
  input  logic              wr_dq_oe,
  input  logic              wr_end,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_bank,
  input  logic [12:0]       rd_addr,
  input  logic              rd_end,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [1:0]        sdram_bank,
  output logic [12:0]       sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  arb_state_e state, state_nxt;
  sdram_cmd_t sel;

  always_ff @(posedge arbit_clk) begin
    if (!arbit_rst_n) state <= ARB_INIT;
    else              state <= state_nxt;
  end

  // Priority is only evaluated in idle; owners release solely via their own end pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_INIT:  if (init_end) state_nxt = ARB_IDLE;
      ARB_IDLE: begin
        if      (aref_req) state_nxt = ARB_AREF;
        else if (wr_req)   state_nxt = ARB_WRITE;
        else if (rd_req)   state_nxt = ARB_READ;
      end
      ARB_AREF:  if (aref_end) state_nxt = ARB_IDLE;
      ARB_WRITE: if (wr_end)   state_nxt = ARB_IDLE;
      ARB_READ:  if (rd_end)   state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_INIT;
    endcase
  end

  always_comb begin
    sel = '{cmd: CMD_NOP, bank: 2'd0, addr: 13'd0};
    case (state)
      ARB_INIT:  sel = '{cmd: init_cmd, bank: init_bank, addr: init_addr};
      ARB_AREF:  sel = '{cmd: aref_cmd, bank: aref_bank, addr: aref_addr};
      ARB_WRITE: sel = '{cmd: wr_cmd,   bank: wr_bank,   addr: wr_addr};
      ARB_READ:  sel = '{cmd: rd_cmd,   bank: rd_bank,   addr: rd_addr};
      default:   ;
    endcase
  end

  assign sdram_cmd    = sel.cmd;
  assign sdram_bank   = sel.bank;
  assign sdram_addr   = sel.addr;
  assign aref_en      = (state == ARB_AREF);
  assign wr_en        = (state == ARB_WRITE);
  assign rd_en        = (state == ARB_READ);
  assign sdram_cke    = 1'b1;
  assign sdram_dq_out = wr_dq;
  assign sdram_dq_oe  = (state == ARB_WRITE) & wr_dq_oe;

endmodule
